// File: rtl/weight_load_ctrl.sv
// Weight tile loader: Avalon-MM burst reads of WEIGHT_NUM words from base_addr,
// streamed in order into the weight buffer at addresses 0..WEIGHT_NUM-1.
module weight_load_ctrl #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int CW         = 16,
   parameter int WEIGHT_NUM = 64,
   parameter int BURST_LEN  = 16,
   parameter int BW         = 5,
   parameter int RAM_AW     = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [AW-1:0]     base_addr,
   output logic              busy,
   output logic              done,
   output logic [AW-1:0]     avm_address,
   output logic              avm_read,
   output logic [BW-1:0]     avm_burstcount,
   input  logic              avm_waitrequest,
   input  logic [DW-1:0]     avm_readdata,
   input  logic              avm_readdatavalid,
   output logic              wr_ena,
   output logic [RAM_AW-1:0] wr_addr,
   output logic [DW-1:0]     wr_data
);

   typedef enum logic [1:0] {IDLE, REQ, DATA, FIN} state_t;

   localparam logic [CW-1:0] WORDS      = CW'(WEIGHT_NUM);
   localparam logic [CW-1:0] BURST      = CW'(BURST_LEN);
   localparam logic [AW-1:0] WORD_BYTES = AW'(DW / 8);

   state_t              state_reg, state_next;
   logic [CW-1:0]       word_cnt_reg;
   logic [CW-1:0]       beat_cnt_reg;
   logic [AW-1:0]       addr_reg;
   logic [BW-1:0]       burst_reg;
   logic                wr_ena_reg;
   logic [RAM_AW-1:0]   wr_addr_reg;
   logic [DW-1:0]       wr_data_reg;

   logic                accept;
   logic                beat;
   logic                last_beat;
   logic                more_words;
   logic [CW-1:0]       word_inc;
   logic [CW-1:0]       beat_inc;
   logic [CW-1:0]       remaining;
   logic [BW-1:0]       burst_first;
   logic [BW-1:0]       burst_after;

   assign accept      = (state_reg == REQ) && !avm_waitrequest;
   assign beat        = (state_reg == DATA) && avm_readdatavalid;
   assign word_inc    = word_cnt_reg + CW'(1);
   assign beat_inc    = beat_cnt_reg + CW'(1);
   assign last_beat   = beat && (beat_inc == CW'(burst_reg));
   assign more_words  = word_inc < WORDS;

   // Burst sizing: full bursts until the tail, which may be short.
   assign remaining   = WORDS - word_inc;
   assign burst_first = (WORDS > BURST) ? BW'(BURST_LEN) : BW'(WEIGHT_NUM);
   assign burst_after = (remaining > BURST) ? BW'(BURST_LEN) : BW'(remaining);

   always_comb begin
      state_next = state_reg;
      busy       = 1'b0;
      done       = 1'b0;
      avm_read   = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = REQ;
            end
         end
         REQ: begin
            busy     = 1'b1;
            avm_read = 1'b1;
            if (accept) begin
               state_next = DATA;
            end
         end
         DATA: begin
            busy = 1'b1;
            if (last_beat) begin
               state_next = more_words ? REQ : FIN;
            end
         end
         FIN: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg    <= IDLE;
         word_cnt_reg <= '0;
         beat_cnt_reg <= '0;
         addr_reg     <= '0;
         burst_reg    <= '0;
         wr_ena_reg   <= 1'b0;
         wr_addr_reg  <= '0;
         wr_data_reg  <= '0;
      end else begin
         state_reg  <= state_next;
         wr_ena_reg <= beat;
         if (beat) begin
            wr_addr_reg <= RAM_AW'(word_cnt_reg);
            wr_data_reg <= avm_readdata;
         end
         unique case (state_reg)
            IDLE: begin
               if (start) begin
                  addr_reg     <= base_addr;
                  word_cnt_reg <= '0;
                  burst_reg    <= burst_first;
               end
            end
            REQ: begin
               if (accept) begin
                  beat_cnt_reg <= '0;
               end
            end
            DATA: begin
               if (beat) begin
                  word_cnt_reg <= word_inc;
                  beat_cnt_reg <= beat_inc;
                  // Next burst starts right after the words just fetched.
                  if (last_beat && more_words) begin
                     addr_reg  <= addr_reg + AW'(burst_reg) * WORD_BYTES;
                     burst_reg <= burst_after;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign avm_address    = addr_reg;
   assign avm_burstcount = burst_reg;
   assign wr_ena         = wr_ena_reg;
   assign wr_addr        = wr_addr_reg;
   assign wr_data        = wr_data_reg;

endmodule
